// File: rtl/counter_target_sequencer.sv
// Drives a counter-bank channel toward a target value along the shorter
// wrap-around direction and reports the cycles taken, a range error, a timeout or an abort.
module counter_target_sequencer #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CW_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_sel,
  input  logic [7:0]      cmd_target,
  input  logic            cmd_comp,
  input  logic            abort,
  input  logic [7:0]      yin,
  output logic [1:0]      sel,
  output logic            up_down,
  output logic            comp,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [CW_W-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_DIR,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  localparam int unsigned CMAX =
    (CW_W >= 17) ? 32'h1FFFF : (32'd1 << CW_W) - 32'd1;

  state_t          state_q, state_d;
  logic [1:0]      lsel_q, lsel_d;
  logic [7:0]      tgt_q, tgt_d;
  logic            ccfg_q, ccfg_d;
  logic [1:0]      sel_q, sel_d;
  logic            ud_q, ud_d;
  logic [1:0]      code_q, code_d;
  logic [CW_W-1:0] cyc_q, cyc_d;
  logic [3:0]      stl_q, stl_d;
  logic [15:0]     run_q, run_d;
  logic [7:0]      start_q, start_d;

  logic [7:0]      mask;
  logic [7:0]      d_up;
  logic [7:0]      d_dn;
  logic [16:0]     run_nxt;
  logic            match;

  function automatic logic [7:0] wmask(input logic [1:0] s);
    return 8'hFF >> (2'd3 - s);
  endfunction

  assign mask    = wmask(lsel_q);
  assign d_up    = (tgt_q - start_q) & mask;
  assign d_dn    = (start_q - tgt_q) & mask;
  assign run_nxt = {1'b0, run_q} + 17'd1;
  assign match   = (yin & mask) == tgt_q;

  always_comb begin
    state_d = state_q;
    lsel_d  = lsel_q;
    tgt_d   = tgt_q;
    ccfg_d  = ccfg_q;
    sel_d   = sel_q;
    ud_d    = ud_q;
    code_d  = code_q;
    cyc_d   = cyc_q;
    stl_d   = stl_q;
    run_d   = run_q;
    start_d = start_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          lsel_d = cmd_sel;
          tgt_d  = cmd_target;
          ccfg_d = cmd_comp;
          code_d = 2'b00;
          cyc_d  = '0;
          run_d  = '0;
          stl_d  = 4'(SETTLE_CYC - 1);
          if ((cmd_target & ~wmask(cmd_sel)) != 8'd0) begin
            code_d  = 2'b01;
            state_d = S_ERR;
          end else begin
            sel_d   = cmd_sel;
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (abort) begin
          code_d  = 2'b11;
          state_d = S_ERR;
        end else if (stl_q == 4'd0) begin
          start_d = yin & mask;
          state_d = S_DIR;
        end else begin
          stl_d = stl_q - 4'd1;
        end
      end
      S_DIR: begin
        if (abort) begin
          code_d  = 2'b11;
          state_d = S_ERR;
        end else begin
          ud_d    = d_up <= d_dn;
          state_d = (d_up == 8'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        run_d = run_nxt[15:0];
        if (abort) begin
          code_d  = 2'b11;
          state_d = S_ERR;
        end else if (match) begin
          cyc_d   = (32'(run_nxt) > CMAX) ? '1 : CW_W'(run_nxt);
          state_d = S_DONE;
        end else if (32'(run_nxt) >= TIMEOUT) begin
          code_d  = 2'b10;
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lsel_q  <= '0;
      tgt_q   <= '0;
      ccfg_q  <= 1'b0;
      sel_q   <= '0;
      ud_q    <= 1'b1;
      code_q  <= '0;
      cyc_q   <= '0;
      stl_q   <= '0;
      run_q   <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      lsel_q  <= lsel_d;
      tgt_q   <= tgt_d;
      ccfg_q  <= ccfg_d;
      sel_q   <= sel_d;
      ud_q    <= ud_d;
      code_q  <= code_d;
      cyc_q   <= cyc_d;
      stl_q   <= stl_d;
      run_q   <= run_d;
      start_q <= start_d;
    end
  end

  assign cmd_ready = state_q == S_IDLE;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign err       = state_q == S_ERR;
  assign comp      = (state_q == S_RUN) & ccfg_q;
  assign sel       = sel_q;
  assign up_down   = ud_q;
  assign err_code  = code_q;
  assign cycles    = cyc_q;

endmodule

// File: tb/tb_counter_target_sequencer.sv
// Directed bench: the bench plays the counter bank, driving yin per cycle
// from a start value and step, and checks each command's outcome.
module tb_counter_target_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_sel;
  logic [7:0]  cmd_target;
  logic        cmd_comp;
  logic        abort;
  logic [7:0]  yin;
  logic [1:0]  sel;
  logic        up_down;
  logic        comp;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] cycles;

  int checks = 0;
  int errors = 0;

  counter_target_sequencer #(
    .SETTLE_CYC(2),
    .TIMEOUT(8),
    .CW_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel),
    .cmd_target(cmd_target),
    .cmd_comp(cmd_comp),
    .abort(abort),
    .yin(yin),
    .sel(sel),
    .up_down(up_down),
    .comp(comp),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  tgt;
    logic        comp;
    int          start;
    int          step;
    logic [7:0]  junk;
    int          abort_at;
    int          exp_at;
    logic [1:0]  exp_code;
    logic [15:0] exp_cyc;
    logic        exp_ud;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] yval(input vec_t v, input int i);
    int         t;
    logic [7:0] m;
    m = 8'((1 << (5 + int'(v.sel))) - 1);
    t = v.start + v.step * ((i > 3) ? (i - 3) : 0);
    return (8'(t) & m) | (v.junk & ~m);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int i;
    bit seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_sel    = v.sel;
    cmd_target = v.tgt;
    cmd_comp   = v.comp;
    abort      = (v.abort_at == 0);
    yin        = yval(v, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 0;
    i = 1;
    while (!seen && i <= 40) begin
      if (done || err) begin
        seen = 1;
      end else begin
        if (i == 4 && v.exp_at > 4)
          chk({tag, " comp"}, 32'(comp), 32'(v.comp));
        yin   = yval(v, i);
        abort = (i == v.abort_at);
        @(negedge clk);
        i++;
      end
    end
    abort = 1'b0;
    if (!seen) begin
      chk({tag, " no_finish"}, 32'(i), 32'(v.exp_at));
    end else begin
      chk({tag, " at"}, 32'(i), 32'(v.exp_at));
      chk({tag, " done"}, 32'(done), 32'(v.exp_code == 2'b00));
      chk({tag, " err"}, 32'(err), 32'(v.exp_code != 2'b00));
      chk({tag, " code"}, 32'(err_code), 32'(v.exp_code));
      chk({tag, " cycles"}, 32'(cycles), 32'(v.exp_cyc));
      chk({tag, " up_down"}, 32'(up_down), 32'(v.exp_ud));
      chk({tag, " sel"}, 32'(sel), 32'(v.exp_sel));
    end
    @(negedge clk);
    chk({tag, " pulse_end"}, {29'd0, done, err, busy}, 32'd0);
    chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    vt[0]  = '{2'd0, 8'd5,   1'b1, 0,   1,  8'h00, -1, 9,  2'b00, 16'd5, 1'b1, 2'd0};
    vt[1]  = '{2'd0, 8'd30,  1'b0, 2,   -1, 8'h00, -1, 8,  2'b00, 16'd4, 1'b0, 2'd0};
    vt[2]  = '{2'd1, 8'd64,  1'b0, 0,   0,  8'h00, -1, 1,  2'b01, 16'd0, 1'b0, 2'd0};
    vt[3]  = '{2'd0, 8'd20,  1'b1, 10,  0,  8'h00, -1, 12, 2'b10, 16'd0, 1'b1, 2'd0};
    vt[4]  = '{2'd2, 8'd100, 1'b1, 97,  1,  8'h00, 6,  7,  2'b11, 16'd0, 1'b1, 2'd2};
    vt[5]  = '{2'd3, 8'd200, 1'b0, 200, 0,  8'h00, -1, 4,  2'b00, 16'd0, 1'b1, 2'd3};
    vt[6]  = '{2'd1, 8'd60,  1'b1, 3,   -1, 8'hC0, -1, 11, 2'b00, 16'd7, 1'b0, 2'd1};
    vt[7]  = '{2'd0, 8'd16,  1'b0, 0,   1,  8'h00, -1, 12, 2'b10, 16'd0, 1'b1, 2'd0};
    vt[8]  = '{2'd0, 8'd3,   1'b0, 0,   1,  8'h00, 1,  2,  2'b11, 16'd0, 1'b1, 2'd0};
    vt[9]  = '{2'd0, 8'd1,   1'b0, 0,   1,  8'h00, 0,  5,  2'b00, 16'd1, 1'b1, 2'd0};
    vt[10] = '{2'd0, 8'd31,  1'b0, 0,   -1, 8'h00, -1, 5,  2'b00, 16'd1, 1'b0, 2'd0};

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_sel    = 2'd0;
    cmd_target = 8'd0;
    cmd_comp   = 1'b0;
    abort      = 1'b0;
    yin        = 8'd0;
    #12;
    chk("rst sel", 32'(sel), 32'd0);
    chk("rst up_down", 32'(up_down), 32'd1);
    chk("rst flags", {28'd0, comp, busy, done, err}, 32'd0);
    chk("rst code", 32'(err_code), 32'd0);
    chk("rst cycles", 32'(cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ready", 32'(cmd_ready), 32'd1);

    for (int k = 0; k < 11; k++) run_vec(vt[k], k);

    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_sel    = 2'd2;
    cmd_target = 8'd5;
    yin        = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid busy", 32'(busy), 32'd1);
    chk("mid sel", 32'(sel), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid rst sel", 32'(sel), 32'd0);
    chk("mid rst up_down", 32'(up_down), 32'd1);
    chk("mid rst flags", {28'd0, comp, busy, done, err}, 32'd0);
    chk("mid rst code", 32'(err_code), 32'd0);
    chk("mid rst cycles", 32'(cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post rst quiet", {29'd0, done, err, busy}, 32'd0);
    end
    chk("post rst ready", 32'(cmd_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
